// File: rtl/mul_div_unit_if.sv
// Operand, move and result bundle between the decode/register-file stage and the
// multiply/divide unit; the controller drives the master side.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HI_Write;
  logic             LO_Write;
  logic [WIDTH-1:0] W_Data;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, A, B, HI_Write, LO_Write, W_Data,
    input  HI, LO, Busy, Done
  );

  modport slave (
    input  Start, Op, A, B, HI_Write, LO_Write, W_Data,
    output HI, LO, Busy, Done
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Works on operand magnitudes for WIDTH cycles, then applies sign correction once.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic           Clk,
  input logic           Reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_load;
  logic               w_iter;
  logic               w_finish;

  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_sign_a;
  logic               w_sign_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_iter       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_load       = 1'b1;
          w_state_next = CALC;
        end
      end
      CALC: begin
        w_iter = 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) w_state_next = FINISH;
      end
      FINISH: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Op[0] marks the signed variants; unsigned operands never count as negative.
  assign w_sign_a = bus.Op[0] & bus.A[WIDTH-1];
  assign w_sign_b = bus.Op[0] & bus.B[WIDTH-1];
  assign w_mag_a  = w_sign_a ? -bus.A : bus.A;
  assign w_mag_b  = w_sign_b ? -bus.B : bus.B;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
  assign w_div_next  = w_div_diff[WIDTH] ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                         : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quo  = r_acc[WIDTH-1:0];
  assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fin = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_mag_b == '0) begin
        // Re-sign the stored magnitude to recover the original dividend.
        w_hi_fin = r_neg_rem ? -r_mag_a : r_mag_a;
        w_lo_fin = '1;
      end else begin
        w_hi_fin = r_neg_rem ? -w_rem : w_rem;
        w_lo_fin = r_neg_res ? -w_quo : w_quo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_op      <= '0;
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_op      <= bus.Op;
        r_mag_a   <= w_mag_a;
        r_mag_b   <= w_mag_b;
        r_neg_res <= w_sign_a ^ w_sign_b;
        r_neg_rem <= w_sign_a;
        r_cnt     <= '0;
        r_acc     <= {{WIDTH{1'b0}}, (bus.Op[1] ? w_mag_a : w_mag_b)};
      end else if (w_iter) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_op[1] ? w_div_next : w_mul_next;
      end
    end
  end

  // Moves are honoured only in IDLE; FINISH never coincides with IDLE.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_finish) begin
      r_hi <= w_hi_fin;
      r_lo <= w_lo_fin;
    end else if (r_state == IDLE) begin
      if (bus.HI_Write) r_hi <= bus.W_Data;
      if (bus.LO_Write) r_lo <= bus.W_Data;
    end
  end

  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
  assign bus.Busy = (r_state != IDLE);
  assign bus.Done = r_done;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised bench for mul_div_unit, checked against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result from integer arithmetic (division truncates toward zero).
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint     sa;
    longint     sb;
    longint     p;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = a / b;
          hi = a % b;
        end else begin
          p  = sa / sb;
          lo = p[31:0];
          p  = sa % sb;
          hi = p[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(7, 0))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Entered and left at #1 after a rising edge; returns in the Done cycle.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit interfere, input bit with_move, input string tag);
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic [31:0] hi_base;
    logic [31:0] lo_base;
    logic [31:0] wd;
    int          cyc;
    bit          seen;
    bit          stable;
    model(op, a, b, exp_hi, exp_lo);
    wd = $urandom;
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    if (with_move) begin
      bus.HI_Write = 1'b1;
      bus.LO_Write = 1'b1;
      bus.W_Data   = wd;
    end
    @(posedge clk); #1;
    bus.Start    = 1'b0;
    bus.HI_Write = 1'b0;
    bus.LO_Write = 1'b0;
    bus.A        = $urandom;
    bus.B        = $urandom;
    check({tag, "_busy_start"}, bus.Busy, 1);
    if (with_move) begin
      check({tag, "_move_hi"}, bus.HI, wd);
      check({tag, "_move_lo"}, bus.LO, wd);
    end
    hi_base = bus.HI;
    lo_base = bus.LO;
    cyc     = 0;
    seen    = 1'b0;
    stable  = 1'b1;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (interfere && cyc == 1) begin
        bus.Start    = 1'b0;
      end
      if (bus.Done) begin
        seen = 1'b1;
      end else begin
        if (bus.HI !== hi_base || bus.LO !== lo_base || bus.Busy !== 1'b1) stable = 1'b0;
        if (interfere && cyc == 10) begin
          bus.Start    = 1'b1;
          bus.Op       = 2'b00;
          bus.A        = 32'd3;
          bus.B        = 32'd3;
          bus.HI_Write = 1'b1;
          bus.LO_Write = 1'b1;
          bus.W_Data   = $urandom;
        end else if (interfere && cyc == 11) begin
          bus.Start    = 1'b0;
          bus.HI_Write = 1'b0;
          bus.LO_Write = 1'b0;
        end
      end
    end
    check({tag, "_latency"}, cyc, 33);
    check({tag, "_stable"}, stable, 1);
    check({tag, "_busy_end"}, bus.Busy, 0);
    check({tag, "_hi"}, bus.HI, exp_hi);
    check({tag, "_lo"}, bus.LO, exp_lo);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h) cycles=%0d",
             tag, op, a, b, bus.HI, bus.LO, exp_hi, exp_lo, cyc);
  endtask

  task automatic idle_cycle_done_low(input string tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.Done, 0);
  endtask

  initial begin
    bit never_done;
    bit chain;
    n_compared   = 0;
    n_mismatched = 0;
    reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Op       = 2'b00;
    bus.A        = '0;
    bus.B        = '0;
    bus.HI_Write = 1'b0;
    bus.LO_Write = 1'b0;
    bus.W_Data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", bus.HI, 0);
    check("rst_lo", bus.LO, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    bus.HI_Write = 1'b1;
    bus.W_Data   = 32'h1234_5678;
    @(posedge clk); #1;
    bus.HI_Write = 1'b0;
    check("mthi_hi", bus.HI, 32'h1234_5678);
    check("mthi_lo", bus.LO, 0);
    $display("txn mthi w=12345678 -> hi=%h lo=%h", bus.HI, bus.LO);

    bus.LO_Write = 1'b1;
    bus.W_Data   = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.LO_Write = 1'b0;
    check("mtlo_lo", bus.LO, 32'hCAFE_F00D);
    check("mtlo_hi", bus.HI, 32'h1234_5678);
    $display("txn mtlo w=cafef00d -> hi=%h lo=%h", bus.HI, bus.LO);

    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    idle_cycle_done_low("multu_max");
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, "mult_neg");
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg");
    idle_cycle_done_low("div_neg");
    do_op(2'b10, 32'd100, 32'd0, 0, 0, "divu_zero");
    idle_cycle_done_low("divu_zero");
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    idle_cycle_done_low("div_ovf");
    do_op(2'b11, 32'hFFFF_FFF0, 32'd0, 0, 0, "div_zero_neg");
    idle_cycle_done_low("div_zero_neg");
    do_op(2'b10, 32'd7, 32'd2, 1, 0, "divu_ignore_start");
    do_op(2'b00, 32'd3, 32'd3, 0, 0, "multu_in_done");
    idle_cycle_done_low("multu_in_done");
    do_op(2'b01, 32'hFFFF_0001, 32'h0000_7FFF, 0, 1, "mult_with_move");
    idle_cycle_done_low("mult_with_move");

    // Reset in the middle of a MULT.
    bus.Start = 1'b1;
    bus.Op    = 2'b01;
    bus.A     = 32'hFFFF_FFFD;
    bus.B     = 32'd5;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_hi", bus.HI, 0);
    check("midrst_lo", bus.LO, 0);
    check("midrst_busy", bus.Busy, 0);
    check("midrst_done", bus.Done, 0);
    $display("txn reset mid-mult -> hi=%h lo=%h busy=%b done=%b", bus.HI, bus.LO, bus.Busy, bus.Done);
    @(posedge clk); #1;
    reset = 1'b0;
    never_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) never_done = 1'b0;
    end
    check("midrst_quiet", never_done, 1);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd5, 0, 0, "after_rst");
    idle_cycle_done_low("after_rst");

    for (int n = 0; n < 24; n++) begin
      do_op(2'($urandom_range(3, 0)), pick_val(), pick_val(),
            bit'($urandom_range(3, 0) == 0), bit'($urandom_range(3, 0) == 0),
            $sformatf("rand%0d", n));
      chain = bit'($urandom_range(1, 0));
      if (!chain) idle_cycle_done_low($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit directly downstream of the register file in the R/I-type CPU.
- Consumes the two register read operands (rs, rt) and computes MULT, MULTU, DIV or DIVU over 32 iteration cycles.
- Holds results in architectural HI/LO registers; the write-back path later reads them for MFHI/MFLO.
- A Busy/Done handshake lets the controller stall the pipeline until results are valid.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  request pulse; sampled only in IDLE
- Op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- A  input  WIDTH  rs operand (register file read port A)
- B  input  WIDTH  rt operand (register file read port B)
- HI_Write  input  1  MTHI: load HI from W_Data
- LO_Write  input  1  MTLO: load LO from W_Data
- W_Data  input  WIDTH  data for MTHI/MTLO
- HI  output  WIDTH  HI register (product upper half / remainder)
- LO  output  WIDTH  LO register (product lower half / quotient)
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse; HI/LO valid

Behaviour:
- Reset (asynchronous, effective immediately, including mid-operation):
  - HI=0, LO=0, Busy=0, Done=0.
  - State=IDLE, iteration counter=0, internal operand registers cleared.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Start=1 at edge E0: latch Op, latch magnitudes of A and B, latch result-sign flags, set counter=0, go to CALC.
  - Busy=1 from E0.
  - Magnitudes: for signed ops, a negative operand is two's-complemented; the result is taken as unsigned WIDTH bits, so 0x80000000 gives 0x80000000.
- CALC: one iteration per edge, counter increments; after 32 iterations (edge E32) go to FINISH.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring divide over a WIDTH remainder and WIDTH quotient.
- FINISH, edge E33:
  - Apply sign correction and write HI/LO. Go to IDLE, Busy=0, Done=1 for exactly one cycle (the cycle after E33).
  - Total latency: Start sampled at E0, results visible after E33.
- Sign rules:
  - MULT: 64-bit product negated when sign(A)^sign(B).
  - DIV: quotient negated when sign(A)^sign(B); remainder takes the sign of A.
- Divide by zero (B==0, signed or unsigned):
  - HI=A (original value), LO=32'hFFFF_FFFF.
  - Same 33-cycle latency; no exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Handshake and boundary cases:
  - Start while Busy=1 is ignored; no restart.
  - Start in the same cycle as Done=1 is accepted, since the state is IDLE.
  - HI_Write/LO_Write act only when Busy=0; while Busy=1 they are ignored.
  - HI_Write and LO_Write may both be asserted in one cycle; both load W_Data.
  - If HI_Write/LO_Write and Start arrive in the same IDLE cycle, the move writes and the operation is accepted. Finish results later overwrite HI/LO.
- HI/LO are unchanged during CALC; no partial results are visible.
- A and B are sampled only at E0; later changes on A/B have no effect.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high for 33 cycles, Done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF after 33 cycles. DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 7/2 running; Start with MULTU 3*3 at cycle 10 -> ignored, result HI=1, LO=3. Start pulsed in the Done cycle -> accepted, HI=0, LO=9 after a further 33 cycles.
- HI_Write W_Data=0x12345678 when idle -> HI=0x12345678 next cycle. LO_Write during Busy -> LO unchanged.
- Assert Reset at cycle 15 of a MULT -> HI=LO=0, Busy=0, Done=0 immediately. No Done afterwards; a new Start works normally.
